// File: rtl/maze_mem_arbiter.sv
// Arbitrates one single-port maze RAM between the VGA renderer (fixed slot every
// 4th clock) and game logic (req/ack handshake, one access outstanding).
module maze_mem_arbiter #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 4
) (
    input  logic              ClkPort,
    input  logic              reset,
    output logic              slot_next,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic [DATA_W-1:0] vga_data,
    output logic              vga_valid,
    input  logic              gl_req,
    input  logic              gl_we,
    input  logic [ADDR_W-1:0] gl_addr,
    input  logic [DATA_W-1:0] gl_wdata,
    output logic              gl_ack,
    output logic [DATA_W-1:0] gl_rdata,
    output logic              gl_busy,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    // state | meaning
    // IDLE  | no GL access; may issue at any edge with phase != 0
    // WAIT  | RAM samples the GL access
    // CAPT  | GL read data returns from RAM; raise gl_ack
    // ACK   | ack cycle; drop ack and busy
    typedef enum logic [1:0] {IDLE, WAIT, CAPT, ACK} gl_state_t;

    gl_state_t  gl_state;
    logic [1:0] phase;
    logic       op_we;

    assign slot_next = (phase == 2'd3);

    always_ff @(posedge ClkPort or posedge reset) begin
        if (reset) begin
            phase     <= 2'd0;
            gl_state  <= IDLE;
            op_we     <= 1'b0;
            vga_data  <= '0;
            vga_valid <= 1'b0;
            gl_ack    <= 1'b0;
            gl_rdata  <= '0;
            gl_busy   <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            phase  <= phase + 2'd1;
            mem_en <= 1'b0;
            mem_we <= 1'b0;

            // VGA read issued at phase 0 always returns at the phase-2 edge
            vga_valid <= (phase == 2'd2);
            if (phase == 2'd2)
                vga_data <= mem_rdata;

            if (phase == 2'd0) begin
                mem_en   <= 1'b1;
                mem_addr <= vga_addr;
            end

            case (gl_state)
                IDLE: begin
                    if (gl_req && phase != 2'd0) begin
                        mem_en    <= 1'b1;
                        mem_we    <= gl_we;
                        mem_addr  <= gl_addr;
                        mem_wdata <= gl_wdata;
                        op_we     <= gl_we;
                        gl_busy   <= 1'b1;
                        gl_state  <= WAIT;
                    end
                end
                WAIT: begin
                    gl_state <= CAPT;
                end
                CAPT: begin
                    if (!op_we)
                        gl_rdata <= mem_rdata;
                    gl_ack   <= 1'b1;
                    gl_state <= ACK;
                end
                ACK: begin
                    gl_ack   <= 1'b0;
                    gl_busy  <= 1'b0;
                    gl_state <= IDLE;
                end
                default: gl_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_maze_mem_arbiter.sv
// Directed bench for maze_mem_arbiter with a write-first synchronous RAM model.
module tb_maze_mem_arbiter;

    logic       ClkPort = 1'b0;
    logic       reset = 1'b1;
    logic       slot_next;
    logic [9:0] vga_addr = '0;
    logic [3:0] vga_data;
    logic       vga_valid;
    logic       gl_req = 1'b0;
    logic       gl_we = 1'b0;
    logic [9:0] gl_addr = '0;
    logic [3:0] gl_wdata = '0;
    logic       gl_ack;
    logic [3:0] gl_rdata;
    logic       gl_busy;
    logic       mem_en;
    logic       mem_we;
    logic [9:0] mem_addr;
    logic [3:0] mem_wdata;
    logic [3:0] mem_rdata = '0;

    logic       pre_we = 1'b0;
    logic [9:0] pre_addr = '0;
    logic [3:0] pre_data = '0;
    logic [3:0] ram [0:1023];

    int n_chk = 0;
    int n_bad = 0;
    int cyc = 0;

    maze_mem_arbiter #(.ADDR_W(10), .DATA_W(4)) dut (
        .ClkPort   (ClkPort),
        .reset     (reset),
        .slot_next (slot_next),
        .vga_addr  (vga_addr),
        .vga_data  (vga_data),
        .vga_valid (vga_valid),
        .gl_req    (gl_req),
        .gl_we     (gl_we),
        .gl_addr   (gl_addr),
        .gl_wdata  (gl_wdata),
        .gl_ack    (gl_ack),
        .gl_rdata  (gl_rdata),
        .gl_busy   (gl_busy),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 ClkPort = ~ClkPort;

    // Independent edge count since reset release; phase expectation is cyc % 4
    always @(posedge ClkPort or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    always @(posedge ClkPort) begin
        if (pre_we) begin
            ram[pre_addr] <= pre_data;
        end else if (mem_en) begin
            if (mem_we) begin
                ram[mem_addr] <= mem_wdata;
                mem_rdata     <= mem_wdata;
            end else begin
                mem_rdata <= ram[mem_addr];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge ClkPort);
        @(negedge ClkPort);
    endtask

    task automatic to_phase(input int p);
        for (int k = 0; k < 4 && (cyc % 4) != p; k++) step();
    endtask

    task automatic preload(input logic [9:0] a, input logic [3:0] d);
        pre_we   = 1'b1;
        pre_addr = a;
        pre_data = d;
        step();
        pre_we   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n_vv, n_ack, ack_at, n_conf, n_wide, n_busy, sel;
        logic prev_ack;
        logic [3:0] exp_rd;

        @(negedge ClkPort);
        preload(10'h015, 4'h7);
        preload(10'h3FF, 4'hA);
        preload(10'h020, 4'h5);
        preload(10'h010, 4'h9);

        // reset state
        check("rst_mem_en", mem_en, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_gl_busy", gl_busy, 0);
        check("rst_gl_ack", gl_ack, 0);
        check("rst_vga_valid", vga_valid, 0);
        check("rst_slot_next", slot_next, 0);

        // VGA slot cadence
        vga_addr = 10'h015;
        reset = 1'b0;
        n_vv = 0;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (k == 1) begin
                check("vga_issue_en", mem_en, 1);
                check("vga_issue_addr", mem_addr, 10'h015);
                check("vga_issue_we", mem_we, 0);
            end
            check("slot_next_phase", slot_next, (cyc % 4) == 3);
            check("vga_valid_phase", vga_valid, (cyc % 4) == 3);
            if (vga_valid) n_vv++;
            if ((cyc % 4) == 3) check("vga_data_015", vga_data, 4'h7);
        end
        check("vga_valid_count", n_vv, 3);

        // GL read asserted for a phase-1 edge
        to_phase(1);
        gl_req = 1'b1; gl_we = 1'b0; gl_addr = 10'h3FF;
        step();
        check("rd_mem_addr", mem_addr, 10'h3FF);
        check("rd_mem_en", mem_en, 1);
        check("rd_busy", gl_busy, 1);
        step();
        check("rd_ack_early", gl_ack, 0);
        step();
        check("rd_ack", gl_ack, 1);
        check("rd_data", gl_rdata, 4'hA);
        gl_req = 1'b0;
        step();
        check("rd_ack_drop", gl_ack, 0);
        check("rd_busy_drop", gl_busy, 0);

        // GL request arriving at a phase-0 edge is pushed back one cycle
        to_phase(0);
        gl_req = 1'b1; gl_addr = 10'h020;
        step();
        check("p0_vga_owns", mem_addr, 10'h015);
        check("p0_not_busy", gl_busy, 0);
        step();
        check("p0_gl_addr", mem_addr, 10'h020);
        step();
        check("p0_ack_early", gl_ack, 0);
        step();
        check("p0_ack", gl_ack, 1);
        check("p0_data", gl_rdata, 4'h5);
        gl_req = 1'b0;
        step();

        // GL write then VGA read of the same cell
        to_phase(1);
        gl_req = 1'b1; gl_we = 1'b1; gl_addr = 10'h010; gl_wdata = 4'h3;
        step();
        check("wr_mem_we", mem_we, 1);
        check("wr_mem_wdata", mem_wdata, 4'h3);
        step();
        check("wr_mem_we_pulse", mem_we, 0);
        step();
        check("wr_ack", gl_ack, 1);
        check("wr_rdata_held", gl_rdata, 4'h5);
        gl_req = 1'b0; gl_we = 1'b0;
        vga_addr = 10'h010;
        step();
        check("wr_ack_drop", gl_ack, 0);
        to_phase(0);
        step();
        step();
        step();
        check("raw_vga_valid", vga_valid, 1);
        check("raw_vga_data", vga_data, 4'h3);

        // Held request with alternating addresses
        to_phase(1);
        sel = 0;
        gl_addr = 10'h015;
        gl_req = 1'b1;
        n_ack = 0; n_conf = 0; n_wide = 0; n_busy = 0;
        prev_ack = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            step();
            if ((cyc % 4) == 1 && !(mem_en && !mem_we && mem_addr == vga_addr)) n_conf++;
            if (prev_ack && gl_ack) n_wide++;
            if (prev_ack && gl_busy) n_busy++;
            if (gl_ack) begin
                n_ack++;
                exp_rd = (sel == 0) ? 4'h7 : 4'hA;
                check("hold_rdata", gl_rdata, exp_rd);
                sel = 1 - sel;
                gl_addr = (sel == 0) ? 10'h015 : 10'h3FF;
            end
            prev_ack = gl_ack;
        end
        gl_req = 1'b0;
        check("hold_ack_count", n_ack, 10);
        check("hold_vga_conflict", n_conf, 0);
        check("hold_ack_wide", n_wide, 0);
        check("hold_busy_gap", n_busy, 0);
        step();

        // Reset during WAIT, request still held afterwards
        to_phase(1);
        gl_req = 1'b1; gl_we = 1'b0; gl_addr = 10'h3FF;
        step();
        check("rw_busy_before", gl_busy, 1);
        reset = 1'b1;
        #1;
        check("rw_mem_en", mem_en, 0);
        check("rw_mem_addr", mem_addr, 0);
        check("rw_busy", gl_busy, 0);
        check("rw_ack", gl_ack, 0);
        check("rw_rdata", gl_rdata, 0);
        check("rw_vga_data", vga_data, 0);
        step();
        check("rw_ack_in_reset", gl_ack, 0);
        reset = 1'b0;
        n_ack = 0; ack_at = -1;
        for (int k = 1; k <= 6; k++) begin
            step();
            if (k == 1) check("rw_p0_blocked", gl_busy, 0);
            if (gl_ack) begin
                n_ack++;
                ack_at = cyc;
                check("rw_rdata_after", gl_rdata, 4'hA);
            end
        end
        gl_req = 1'b0;
        check("rw_ack_count", n_ack, 1);
        check("rw_ack_cycle", ack_at, 4);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
